// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller for a simple load/store pipeline.
// Classifies each requested operation, issues a single data-memory
// request for aligned loads/stores, waits for the completion strobe
// with a bounded wait, and reports completion with a one-cycle done
// pulse plus an error flag. busy stalls the pipeline outside IDLE.
module mem_access_ctrl #(
  // Number of ACCESS cycles without mem_ack before the access is aborted.
  // The wait counter is 5 bits wide, so TIMEOUT must lie in 1..32.
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] ALU_Result,
  input  logic [31:0] Write_data,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] Read_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Last counter value of an access; reaching it without mem_ack aborts.
  localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [4:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic        err_q, err_d;

  // Operation classification of the request presented at start.
  logic no_mem_op;   // neither load nor store: ALU pass-through
  logic illegal_op;  // load and store requested together
  logic misaligned;  // single memory op to a non word-aligned address

  assign no_mem_op  = ~MemRead & ~MemWrite;
  assign illegal_op = MemRead & MemWrite;
  assign misaligned = (MemRead ^ MemWrite) & (|ALU_Result[1:0]);

  // Next-state and datapath-update logic; every register holds by default.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    we_d       = we_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Request fields are captured for every started operation so
          // the memory-side outputs reflect the latest request.
          addr_d     = ALU_Result;
          wdata_d    = Write_data;
          we_d       = MemWrite;
          wait_cnt_d = 5'd0;
          if (no_mem_op) begin
            state_d = DONE;
            err_d   = 1'b0;
          end else if (illegal_op || misaligned) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            err_d   = 1'b0;
          end
        end
      end

      ACCESS: begin
        // An acknowledge always wins, even in the final wait cycle.
        if (mem_ack) begin
          state_d = DONE;
          err_d   = 1'b0;
          // Only loads update Read_data; stores never touch it.
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 5'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 5'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      we_q       <= we_d;
      err_q      <= err_d;
    end
  end

  // Outputs are decoded from registered state only, so they are glitch
  // free and stay stable for the whole ACCESS phase.
  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign Read_data = rdata_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign error     = done & err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the stimulus process pushes the
// expected completion of each operation, a negedge monitor pops and
// compares whenever done is presented.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ALU_Result;
  logic [31:0] Write_data;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] Read_data;
  logic        busy;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  mem_access_ctrl #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .ALU_Result (ALU_Result),
    .Write_data (Write_data),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .Read_data  (Read_data),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares each done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("error", 32'(error), 32'(e.err));
        chk("read_data", Read_data, e.rd);
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_wdata", mem_wdata, e.wdata);
        chk("req_low_in_done", 32'(mem_req), 32'h0);
        $display("txn addr=%h we=%0d err=%0d rd=%h done_cyc=%0d", mem_addr, mem_we, error, Read_data, cyc);
      end
    end
  end

  // Issue one operation starting at the current negedge. ack_at is the
  // ACCESS cycle index (0 = first) carrying mem_ack, -1 for none; lat is
  // the hand-computed start-to-done latency in cycles.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ack_at,
                        input logic [31:0] rdata, input logic exp_err,
                        input logic [31:0] exp_rd, input int lat);
    exp_t e;
    e.err = exp_err; e.rd = exp_rd; e.addr = addr; e.we = wr;
    e.wdata = wdata; e.cyc = cyc + lat;
    sb_q.push_back(e);
    MemRead = rd; MemWrite = wr; ALU_Result = addr; Write_data = wdata;
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < lat - 1; k++) begin
      chk("req_in_access", 32'(mem_req), 32'h1);
      chk("addr_stable", mem_addr, addr);
      chk("wdata_stable", mem_wdata, wdata);
      // A start during ACCESS must be ignored.
      start = (k == 0);
      MemRead = 1'b1; MemWrite = 1'b0; ALU_Result = 32'h0000FFF0; Write_data = 32'h55AA55AA;
      mem_ack   = (k == ack_at);
      mem_rdata = (k == ack_at) ? rdata : $urandom;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    if (lat == 1) chk("no_req_direct_done", 32'(mem_req), 32'h0);
    // A start during DONE must be ignored as well.
    start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; ALU_Result = 32'h0000FFF4;
    @(negedge clk);
    start = 1'b0;
    chk("idle_after_done", 32'(busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b1; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    ALU_Result = 32'h0; Write_data = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_read_data", Read_data, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    //     rd  wr  addr          wdata         ack  rdata         err  exp_rd        lat
    run_op(1, 0, 32'h00000040, 32'h00000000,  2, 32'hDEADBEEF, 0, 32'hDEADBEEF,  4);
    run_op(0, 1, 32'h00000080, 32'h00001234,  0, 32'hFFFFFFFF, 0, 32'hDEADBEEF,  2);
    run_op(1, 0, 32'h00000042, 32'h00000000, -1, 32'h0,        1, 32'hDEADBEEF,  1);
    run_op(1, 1, 32'h00000100, 32'h00000009, -1, 32'h0,        1, 32'hDEADBEEF,  1);
    run_op(0, 0, 32'h00000007, 32'h00000003, -1, 32'h0,        0, 32'hDEADBEEF,  1);
    run_op(0, 1, 32'h00000083, 32'h0000BEEF, -1, 32'h0,        1, 32'hDEADBEEF,  1);
    run_op(0, 1, 32'h000000C0, 32'h0000ABCD, -1, 32'h0,        1, 32'hDEADBEEF, 17);
    run_op(1, 0, 32'h00000044, 32'h00000000, 15, 32'hCAFEF00D, 0, 32'hCAFEF00D, 17);
    run_op(1, 0, 32'h00000048, 32'h00000000, -1, 32'h0,        1, 32'hCAFEF00D, 17);
    run_op(1, 0, 32'h0000004C, 32'h00000000,  0, 32'h11223344, 0, 32'h11223344,  2);

    // mem_ack while IDLE must not change anything.
    mem_ack = 1'b1; mem_rdata = 32'h0BADBAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack_busy", 32'(busy), 32'h0);
    chk("idle_ack_read_data", Read_data, 32'h11223344);

    // Reset in the middle of an access.
    MemRead = 1'b1; MemWrite = 1'b0; ALU_Result = 32'h00000050; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pre_rst_req", 32'(mem_req), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_mem_req", 32'(mem_req), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    chk("mid_rst_error", 32'(error), 32'h0);
    chk("mid_rst_mem_we", 32'(mem_we), 32'h0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_wdata", mem_wdata, 32'h0);
    chk("mid_rst_read_data", Read_data, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'h0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the number of ACCESS cycles without mem_ack before the access is aborted.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 start  input  1  SHALL request one memory-stage operation; sampled only in IDLE.
REQ-005 MemRead  input  1  SHALL select a load (LDUR).
REQ-006 MemWrite  input  1  SHALL select a store (STUR).
REQ-007 ALU_Result  input  32  SHALL be the effective address from the ALU.
REQ-008 Write_data  input  32  SHALL be the store data.
REQ-009 mem_ack  input  1  SHALL be the data-memory completion strobe.
REQ-010 mem_rdata  input  32  SHALL be the data-memory read data, valid when mem_ack=1.
REQ-011 mem_req  output  1  SHALL be the data-memory request.
REQ-012 mem_we  output  1  SHALL be the write enable, qualified by mem_req.
REQ-013 mem_addr  output  32  SHALL be the latched address.
REQ-014 mem_wdata  output  32  SHALL be the latched store data.
REQ-015 Read_data  output  32  SHALL hold the last successfully loaded word.
REQ-016 busy  output  1  SHALL be 1 in every state other than IDLE (pipeline stall).
REQ-017 done  output  1  SHALL pulse for one cycle when an operation ends, success or error.
REQ-018 error  output  1  SHALL be valid with done; 1 for misaligned, illegal or timed-out operations.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, DONE; done=1 only in DONE, then unconditional DONE->IDLE.
REQ-020 In IDLE with start=1, ALU_Result, Write_data and MemWrite SHALL be latched into mem_addr, mem_wdata and mem_we.
REQ-021 start with MemRead=MemWrite=0 SHALL go IDLE->DONE with error=0, no mem_req (pass-through for ADD/SUB/etc.).
REQ-022 start with MemRead=MemWrite=1 SHALL go IDLE->DONE with error=1, no mem_req.
REQ-023 start with exactly one of MemRead/MemWrite and ALU_Result[1:0]!=2'b00 SHALL go IDLE->DONE with error=1, no mem_req.
REQ-024 Otherwise start SHALL go IDLE->ACCESS; mem_req=1 from the cycle after start.
REQ-025 mem_req, mem_addr, mem_we, mem_wdata SHALL stay stable throughout ACCESS.
REQ-026 mem_ack=1 in ACCESS SHALL go ACCESS->DONE, drop mem_req the next cycle, error=0; on a load, Read_data<=mem_rdata on that edge.
REQ-027 mem_ack outside ACCESS SHALL be ignored.
REQ-028 A 5-bit wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without mem_ack.
REQ-029 Counter reaching TIMEOUT-1 without mem_ack SHALL go ACCESS->DONE with error=1, Read_data unchanged.
REQ-030 mem_ack in the timeout cycle SHALL take priority: success, error=0.
REQ-031 Minimum latency: start at cycle n, mem_ack at n+1 -> done at n+2; no-access ops -> done at n+1.
REQ-032 start in ACCESS or DONE SHALL be ignored; no queuing.
REQ-033 Stores SHALL never modify Read_data.

Reset
REQ-034 reset=1 SHALL force IDLE; mem_req, mem_we, busy, done, error=0; mem_addr, mem_wdata, Read_data=32'h0; counter=0.
REQ-035 reset SHALL take priority over every other input, including mid-ACCESS; mem_req=0 on the following cycle.

Verification
REQ-036 Load: MemRead=1, ALU_Result=32'h40, start; mem_ack after 3 cycles with mem_rdata=32'hDEADBEEF -> mem_addr=32'h40, mem_we=0, done=1, error=0, Read_data=32'hDEADBEEF.
REQ-037 Store: MemWrite=1, ALU_Result=32'h80, Write_data=32'h1234; mem_ack next cycle -> mem_we=1, mem_wdata=32'h1234, done 2 cycles after start, Read_data unchanged.
REQ-038 Misaligned: MemRead=1, ALU_Result=32'h42 -> done next cycle, error=1, mem_req never 1.
REQ-039 Timeout: store with mem_ack held 0 -> done=1, error=1 after exactly 16 ACCESS cycles; mem_req drops.
REQ-040 Reset mid-ACCESS and mem_ack in timeout cycle -> all outputs at reset values next cycle; ack-at-timeout gives error=0.
